// File: rtl/mem_dram_pkg.sv
// mem_dram_pkg: shared states, address field layout and helpers for the SIP1M9 DRAM controller.
package mem_dram_pkg;
    typedef enum logic [2:0] {IDLE, ROW, COL, PRE, RCAS, RRAS} state_t;
    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 18;
    localparam int AA_W      = 10;
    localparam int BANK_LSB  = 20;
    localparam int ROW_LSB   = 10;
    localparam int NUM_BANKS = 3;
    localparam int CNT_W     = 8;
    // Bank field 3 has no array behind it, so it selects nothing.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] b);
        return (b == 2'd3) ? '0 : NUM_BANKS'(1) << b;
    endfunction
endpackage

// File: rtl/mem_refresh_timer.sv
// mem_refresh_timer: free-running refresh interval counter raising a sticky refresh request.
module mem_refresh_timer
#(
    parameter int REF_INTERVAL = 234
)(
    input  logic sysclk,
    input  logic sys_rst_n,
    input  logic clear,
    output logic ref_pending
);
    localparam int CW = $clog2(REF_INTERVAL + 1);
    logic [CW-1:0] count;
    logic          expire;
    assign expire = count == CW'(1);
    // A new expiry wins over a same-cycle clear so a refresh is never lost.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count       <= CW'(REF_INTERVAL);
            ref_pending <= 1'b0;
        end else begin
            count       <= expire ? CW'(REF_INTERVAL) : count - 1'b1;
            ref_pending <= expire | (ref_pending & ~clear);
        end
    end
endmodule

// File: rtl/mem_dram_ctl.sv
// mem_dram_ctl: single-word read/write and CAS-before-RAS refresh sequencer for the 3-bank DRAM array.
module mem_dram_ctl
    import mem_dram_pkg::*;
#(
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 2,
    parameter int T_RAS_REF    = 3,
    parameter int REF_INTERVAL = 234
)(
    input  logic              sysclk,
    input  logic              sys_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              rsp_aerr,
    output logic [AA_W-1:0]   AA_9_0,
    output logic              BANK0,
    output logic              BANK1,
    output logic              BANK2,
    output logic              RAS,
    output logic              CAS,
    output logic              MWRITE50_n,
    input  logic [DATA_W-1:0] DD_in,
    output logic [DATA_W-1:0] DD_out,
    output logic              DD_oe,
    input  logic              CORR_n
);
    localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(T_CAS - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(T_RAS_REF - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [ADDR_W-1:0]     addr_q, addr_n;
    logic [DATA_W-1:0]     wdata_q, wdata_n;
    logic                  write_q, write_n;
    logic                  ref_pending, ref_clear, accept, bad_bank, col_done, wr_col;
    logic [NUM_BANKS-1:0]  bank_sel;

    mem_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_timer (
        .sysclk      (sysclk),
        .sys_rst_n   (sys_rst_n),
        .clear       (ref_clear),
        .ref_pending (ref_pending)
    );

    assign req_ready = (state == IDLE) && !ref_pending;
    assign bad_bank  = req_addr[BANK_LSB+:2] == 2'd3;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        ref_clear = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (ref_pending) begin
                    state_n   = RCAS;
                    ref_clear = 1'b1;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_n = bad_bank ? IDLE : ROW;
                end
            end
            ROW:  if (cnt == RCD_LAST) begin state_n = COL;  cnt_n = '0; end
            COL:  if (cnt == CAS_LAST) begin state_n = PRE;  cnt_n = '0; end
            PRE:  if (cnt == RP_LAST)  begin state_n = IDLE; cnt_n = '0; end
            RCAS: begin state_n = RRAS; cnt_n = '0; end
            RRAS: if (cnt == REF_LAST) begin state_n = PRE;  cnt_n = '0; end
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change exactly on state entry.
    assign addr_n   = accept ? req_addr  : addr_q;
    assign wdata_n  = accept ? req_wdata : wdata_q;
    assign write_n  = accept ? req_write : write_q;
    assign bank_sel = bank_onehot(addr_n[BANK_LSB+:2]);
    assign wr_col   = (state_n == COL) && write_n;
    assign col_done = (state == COL) && (cnt == CAS_LAST);

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                 <= IDLE;
            cnt                   <= '0;
            addr_q                <= '0;
            wdata_q               <= '0;
            write_q               <= 1'b0;
            RAS                   <= 1'b0;
            CAS                   <= 1'b0;
            {BANK2, BANK1, BANK0} <= '0;
            AA_9_0                <= '0;
            MWRITE50_n            <= 1'b1;
            DD_oe                 <= 1'b0;
            DD_out                <= '0;
            rsp_valid             <= 1'b0;
            rsp_rdata             <= '0;
            rsp_perr              <= 1'b0;
            rsp_aerr              <= 1'b0;
        end else begin
            state                 <= state_n;
            cnt                   <= cnt_n;
            addr_q                <= addr_n;
            wdata_q               <= wdata_n;
            write_q               <= write_n;
            RAS                   <= state_n inside {ROW, COL, RRAS};
            CAS                   <= state_n inside {COL, RCAS, RRAS};
            {BANK2, BANK1, BANK0} <= (state_n inside {ROW, COL}) ? bank_sel :
                                     (state_n inside {RCAS, RRAS}) ? '1 : '0;
            AA_9_0                <= (state_n == ROW) ? addr_n[ROW_LSB+:AA_W] :
                                     (state_n == COL) ? addr_n[AA_W-1:0] : '0;
            MWRITE50_n            <= !wr_col;
            DD_oe                 <= wr_col;
            DD_out                <= wr_col ? wdata_n : '0;
            rsp_valid             <= col_done || (accept && bad_bank);
            if (col_done) begin
                rsp_perr <= !write_q && !CORR_n;
                rsp_aerr <= 1'b0;
                if (!write_q) rsp_rdata <= DD_in;
            end else if (accept && bad_bank) begin
                rsp_perr <= 1'b0;
                rsp_aerr <= 1'b1;
            end
        end
    end
endmodule
